normalize_shifter: RTL
======================

NORMALIZE_SHIFTER -- requirements
Module: normalize_shifter

Interface
REQ-001 SHALL have parameter HIDDEN_BIT, default 23, giving the bit position of the implicit leading 1 in a normalized fraction.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, indicating an unnormalized result is presented.
REQ-005 SHALL have port in_ready, output, 1, high when a new operand can be accepted.
REQ-006 SHALL have port frac_in, input, 32, the raw adder fraction, which may have bits above HIDDEN_BIT set.
REQ-007 SHALL have port exp_in, input, 8, the biased exponent of the raw result.
REQ-008 SHALL have port s_in, input, 1, the sign of the raw result.
REQ-009 SHALL have port out_valid, output, 1, indicating a normalized result is presented to the downstream exception-check stage.
REQ-010 SHALL have port out_ready, input, 1, asserted by the consumer to accept the result.
REQ-011 SHALL have ports frac_out (32), exp_out (8) and s_out (1), all outputs, carrying the normalized fraction, the exponent and the sign.
REQ-012 SHALL have port shift_cnt, output, 6, giving the number of shifts performed for the current result.

Function
REQ-013 SHALL implement the states IDLE, SHIFT and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE with rst_n high, and out_valid = 1 only in DONE.
REQ-015 IDLE: when in_valid and in_ready are both high, SHALL capture frac, exp (held internally as 9 bits, zero-extended) and sign, clear shift_cnt, and move to SHIFT.
REQ-016 SHIFT: SHALL evaluate exactly one rule per cycle, in the priority order REQ-017 to REQ-021.
REQ-017 If frac == 0: SHALL set exp to 0 and move to DONE.
REQ-018 If any of frac[31:HIDDEN_BIT+1] is set: SHALL logically shift frac right by 1, discarding the LSB (truncate, no rounding), set exp = exp+1 and increment shift_cnt. If the new exp is >= 255, it SHALL set exp to 255 and move to DONE.
REQ-019 Else if frac[HIDDEN_BIT] == 1: SHALL move to DONE with no change.
REQ-020 Else if exp <= 1: SHALL set exp to 0 and move to DONE, leaving frac unshifted, so that downstream flushes the result to zero.
REQ-021 Otherwise: SHALL shift frac left by 1, set exp = exp-1 and increment shift_cnt.
REQ-022 DONE: SHALL hold frac_out, exp_out, s_out and shift_cnt stable while out_ready is low. When out_ready is high it SHALL move to IDLE; out_valid drops on the next cycle.
REQ-023 SHALL pass s_out through unchanged from the captured s_in, including when the result is zero.
REQ-024 Latency from the acceptance edge to out_valid SHALL be 2 + (number of shifts) cycles. The maximum is 25 cycles (23 left shifts).
REQ-025 exp_out SHALL never exceed 255; the 9-bit internal exponent SHALL saturate as in REQ-018.
REQ-026 SHALL ignore in_valid while not in IDLE, with no back-to-back acceptance while DONE is held.

Reset
REQ-027 When rst_n is low at a clock edge: the state SHALL go to IDLE, and out_valid, frac_out, exp_out, s_out and shift_cnt SHALL all go to 0.
REQ-028 A reset asserted in SHIFT or DONE SHALL abort the operation, discard its result and produce no out_valid pulse.
REQ-029 in_ready SHALL be 0 while rst_n is low, and 1 from the first cycle after rst_n goes high.

Verification
REQ-030 Normalized input: frac 0x00800000, exp 100, s 1 -> out_valid 2 cycles after acceptance; frac 0x00800000, exp 100, s 1, shift_cnt 0.
REQ-031 Carry-out case: frac 0x01000000, exp 100 -> latency 3; frac 0x00800000, exp 101, shift_cnt 1.
REQ-032 Deep cancellation: frac 0x00000001, exp 127 -> latency 25; frac 0x00800000, exp 104, shift_cnt 23.
REQ-033 Underflow: frac 0x00010000, exp 3 -> frac 0x00040000, exp 0, shift_cnt 2.
REQ-034 Overflow: frac 0x80000000, exp 250 -> frac 0x04000000, exp 255, shift_cnt 5. Zero input: frac 0, exp 90 -> exp 0, latency 2.
REQ-035 Backpressure and reset: hold out_ready low for 10 cycles and check that the outputs stay stable and in_ready stays 0. Then, with a separate operand, assert rst_n low mid-SHIFT and check that out_valid never asserts and that in_ready = 1 on the first cycle after rst_n goes high.

Source files
------------

// File: rtl/normalize_shifter.sv
// Post-add normalizer: shifts a raw fraction one bit per cycle until the hidden bit
// leads, tracking the exponent with saturation at 255 and flush-to-zero at the bottom.
module normalize_shifter #(
    parameter int unsigned HIDDEN_BIT = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] frac_in,
    input  logic [7:0]  exp_in,
    input  logic        s_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] frac_out,
    output logic [7:0]  exp_out,
    output logic        s_out,
    output logic [5:0]  shift_cnt
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    // Bits above the hidden bit; built as a mask so HIDDEN_BIT = 31 needs no empty slice.
    localparam logic [31:0] HighMask = ~((32'd2 << HIDDEN_BIT) - 32'd1);

    state_e      state_q, state_d;
    logic [31:0] frac_q, frac_d;
    logic [8:0]  exp_q, exp_d;
    logic        s_q, s_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [8:0]  exp_inc;

    assign exp_inc = exp_q + 9'd1;

    always_comb begin
        state_d = state_q;
        frac_d  = frac_q;
        exp_d   = exp_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    frac_d  = frac_in;
                    exp_d   = {1'b0, exp_in};
                    s_d     = s_in;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (frac_q == 32'd0) begin
                    exp_d   = '0;
                    state_d = StDone;
                end else if ((frac_q & HighMask) != 32'd0) begin
                    frac_d = frac_q >> 1;
                    cnt_d  = cnt_q + 6'd1;
                    if (exp_inc >= 9'd255) begin
                        exp_d   = 9'd255;
                        state_d = StDone;
                    end else begin
                        exp_d = exp_inc;
                    end
                end else if (frac_q[HIDDEN_BIT]) begin
                    state_d = StDone;
                end else if (exp_q <= 9'd1) begin
                    // Leave frac denormal; the zero exponent makes the next stage flush it.
                    exp_d   = '0;
                    state_d = StDone;
                end else begin
                    frac_d = frac_q << 1;
                    exp_d  = exp_q - 9'd1;
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            frac_q  <= '0;
            exp_q   <= '0;
            s_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            frac_q  <= frac_d;
            exp_q   <= exp_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && rst_n;
    assign out_valid = (state_q == StDone);
    assign frac_out  = frac_q;
    assign exp_out   = exp_q[7:0];
    assign s_out     = s_q;
    assign shift_cnt = cnt_q;

endmodule
